data_mem_interface: RTL and testbench

//  Load/store bus unit directly downstream of memory_stage. Takes the M-stage memory controls and address,

---
 rtl/mem_pkg.sv | 20 ++
 rtl/lsu_align.sv | 55 +++++
 rtl/data_mem_interface.sv | 136 +++++++++++++
 tb/tb_data_mem_interface.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM
// states, byte-enable patterns and the load-extension select value.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // LoadSizeM[0] value that selects zero-extension.
  localparam logic EXT_ZERO = 1'b1;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data for
// stores, and lane extraction plus sign/zero extension for loads.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        zero_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [1:0]  lane;
  logic [31:0] shifted;
  logic        sign_en;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    lane       = 2'b00;
    be         = BE_WORD;
    wdata      = store_data;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        lane  = addr_lo;
        be    = BE_BYTE << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      SIZE_HALF: begin
        lane       = {addr_lo[1], 1'b0};
        be         = BE_HALF << {addr_lo[1], 1'b0};
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

  assign shifted = load_word >> {lane, 3'b000};
  assign sign_en = (zero_ext != EXT_ZERO);

  always_comb begin
    load_data = shifted;
    case (size)
      SIZE_BYTE: load_data = {{24{sign_en & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{16{sign_en & shifted[15]}}, shifted[15:0]};
      default:   load_data = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_interface.sv
// Load/store bus unit: req/ack handshake to data memory with timeout, pipeline
// stall, and extended load return. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module data_mem_interface
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadEnM,
  input  logic              MemWriteEnM,
  input  logic [1:0]        MemSizeM,
  input  logic [1:0]        LoadSizeM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [31:0]       ReadData2M,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ReadDataM,
  output logic              StallM,
  output logic              BusErrM,
  output logic              MisalignM
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic [1:0]       req_size;
  logic [1:0]       req_lo;
  logic             req_zext;

  logic             idle;
  logic             go;
  logic             timeout;
  logic             trap;
  logic [1:0]       sel_size;
  logic [1:0]       sel_lo;
  logic             sel_zext;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [31:0]      load_ext;
  logic             misaligned;
  logic             unused_ext_bit;

  assign idle    = (state == ST_IDLE);
  assign go      = MemReadEnM | MemWriteEnM;
  assign timeout = (count == CNT_W'(TIMEOUT_CYC - 1));
  assign unused_ext_bit = LoadSizeM[1];

  // In IDLE the aligner sees the incoming request; afterwards the latched one.
  assign sel_size = idle ? MemSizeM         : req_size;
  assign sel_lo   = idle ? ALUResultM[1:0]  : req_lo;
  assign sel_zext = idle ? LoadSizeM[0]     : req_zext;

  lsu_align u_align (
    .size       (sel_size),
    .addr_lo    (sel_lo),
    .zero_ext   (sel_zext),
    .store_data (ReadData2M),
    .load_word  (mem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (load_ext),
    .misaligned (misaligned)
  );

`ifdef MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign trap = 1'b0;
`endif

  assign mem_req = (state == ST_REQ);
  assign StallM  = (idle & go) | (state == ST_REQ);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      req_size  <= SIZE_BYTE;
      req_lo    <= 2'b00;
      req_zext  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
      MisalignM <= 1'b0;
    end else begin
      BusErrM   <= 1'b0;
      MisalignM <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            mem_we    <= MemWriteEnM;
            mem_addr  <= ALUResultM[ADDR_W-1:2];
            mem_be    <= MemWriteEnM ? lane_be : BE_WORD;
            mem_wdata <= lane_wdata;
            req_size  <= MemSizeM;
            req_lo    <= ALUResultM[1:0];
            req_zext  <= LoadSizeM[0];
            count     <= '0;
            if (trap) begin
              state     <= ST_DONE;
              MisalignM <= 1'b1;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          count <= count + 1'b1;
          if (mem_ack) begin
            state <= ST_DONE;
            if (!mem_we) ReadDataM <= load_ext;
          end else if (timeout) begin
            state   <= ST_DONE;
            BusErrM <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_interface.sv
// Self-checking bench for data_mem_interface: directed loads/stores against a
// transaction-level model, plus literal expectations for the key scenarios.
module tb_data_mem_interface;

  localparam int ADDR_W      = 32;
  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadEnM, MemWriteEnM;
  logic [1:0]  MemSizeM, LoadSizeM;
  logic [31:0] ALUResultM, ReadData2M;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ReadDataM;
  logic        StallM, BusErrM, MisalignM;

  always #5 clk = ~clk;

  data_mem_interface #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM),
    .MemSizeM(MemSizeM), .LoadSizeM(LoadSizeM),
    .ALUResultM(ALUResultM), .ReadData2M(ReadData2M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ReadDataM(ReadDataM), .StallM(StallM),
    .BusErrM(BusErrM), .MisalignM(MisalignM)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit          model_on = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_we;
  logic [29:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;
  logic [29:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;

  function automatic int lane_of(input logic [1:0] size, input logic [1:0] a);
    if (size == 2'b00) return int'(a);
    if (size == 2'b01) return int'(a) & 2;
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input bit we, input logic [1:0] size, input logic [1:0] a);
    logic [3:0] one = 4'b0001;
    logic [3:0] two = 4'b0011;
    if (!we) return 4'hF;
    if (size == 2'b00) return one << lane_of(size, a);
    if (size == 2'b01) return two << lane_of(size, a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit zext,
                                             input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v = w >> (8 * lane_of(size, a));
    if (size == 2'b00) begin
      v = v & 32'hFF;
      if (!zext && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'b01) begin
      v = v & 32'hFFFF;
      if (!zext && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic bit model_trap(input logic [1:0] size, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
    if (size == 2'b01) return a[0];
    if (size != 2'b00) return a != 2'b00;
    return 0;
`else
    return size == 2'b11 && a == 2'b11 && 0;
`endif
  endfunction

  // Compare process: load result every cycle, bus fields whenever a request is up.
  always @(negedge clk) begin
    if (model_on) begin
      check("ReadDataM", ReadDataM, exp_rdata);
      if (mem_req) begin
        check("mem_we", 32'(mem_we), 32'(exp_we));
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        check("mem_be", 32'(mem_be), 32'(exp_be));
        check("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  // One pipeline access; ack_at = REQ cycle carrying mem_ack (0 = never).
  task automatic run(input bit we, input logic [1:0] size, input bit zext,
                     input logic [31:0] addr, input logic [31:0] d,
                     input logic [31:0] rword, input int ack_at, output int stall_n);
    bit trap = model_trap(size, addr[1:0]);
    int exp_req = trap ? 0 : (ack_at == 0 ? TIMEOUT_CYC : ack_at);
    bit done = 0, acked = 0, err = 0, mis = 0;
    int cyc = 0, req_n = 0;
    stall_n = 0;
    exp_we    = we;
    exp_addr  = addr[31:2];
    exp_be    = model_be(we, size, addr[1:0]);
    exp_wdata = model_wdata(size, d);
    @(posedge clk); #1;
    MemWriteEnM = we; MemReadEnM = !we; MemSizeM = size; LoadSizeM = {1'b0, zext};
    ALUResultM = addr; ReadData2M = d; mem_rdata = rword;
    while (!done && cyc < 100) begin
      cyc++;
      if (mem_req) req_n++;
      mem_ack = mem_req && (req_n == ack_at);
      @(negedge clk);
      if (mem_req) begin obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; end
      if (StallM) stall_n++;
      else begin done = 1; err = BusErrM; mis = MisalignM; end
      if (!done) begin
        acked = mem_ack;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (acked && !we) exp_rdata = model_load(size, zext, addr[1:0], rword);
      end
    end
    check("access_completes", 32'(done), 32'd1);
    check("req_cycles", 32'(req_n), 32'(exp_req));
    check("stall_cycles", 32'(stall_n), 32'(1 + exp_req));
    check("BusErrM_in_done", 32'(err), 32'(!trap && ack_at == 0));
    check("MisalignM_in_done", 32'(mis), 32'(trap));
    @(posedge clk); #1;
    MemReadEnM = 1'b0; MemWriteEnM = 1'b0;
    @(negedge clk);
    check("flags_clear_after_done", 32'({BusErrM, MisalignM, StallM, mem_req}), 32'd0);
  endtask

  int st;

  initial begin
    rst = 1'b1; MemReadEnM = 0; MemWriteEnM = 0; MemSizeM = 0; LoadSizeM = 0;
    ALUResultM = 0; ReadData2M = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ReadDataM", ReadDataM, 0);
    check("rst_flags", 32'({StallM, BusErrM, MisalignM}), 0);
    @(posedge clk); #1;
    rst = 1'b0; exp_rdata = '0; model_on = 1;

    // Stray ack while idle must be ignored.
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    check("idle_ack_ignored", 32'({mem_req, StallM}), 0);
    @(posedge clk); #1; mem_ack = 1'b0;

    run(1, 2'b00, 0, 32'h103, 32'h0000_00A5, 32'h0, 1, st);
    check("sb_be", 32'(obs_be), 32'h8);
    check("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
    check("sb_addr", 32'(obs_addr), 32'h40);
    check("sb_stall", 32'(st), 2);

    run(0, 2'b00, 0, 32'h101, 32'h0, 32'h0000_8000, 1, st);
    check("lb_result", ReadDataM, 32'hFFFF_FF80);
    run(0, 2'b00, 1, 32'h101, 32'h0, 32'h0000_8000, 1, st);
    check("lbu_result", ReadDataM, 32'h0000_0080);

    run(1, 2'b01, 0, 32'h102, 32'h1234_BEEF, 32'h0, 2, st);
    check("sh_be", 32'(obs_be), 32'hC);
    check("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
    check("store_keeps_ReadDataM", ReadDataM, 32'h0000_0080);

    run(0, 2'b01, 0, 32'h102, 32'h0, 32'h8001_0000, 5, st);
    check("lh_result", ReadDataM, 32'hFFFF_8001);
    check("lh_stall", 32'(st), 6);
    run(0, 2'b01, 1, 32'h100, 32'h0, 32'h1234_F00D, 3, st);
    check("lhu_result", ReadDataM, 32'h0000_F00D);

    run(0, 2'b10, 0, 32'h200, 32'h0, 32'h5555_5555, 0, st);
    check("timeout_keeps_ReadDataM", ReadDataM, 32'h0000_F00D);
    check("timeout_stall", 32'(st), 17);

    run(0, 2'b11, 0, 32'h10, 32'h0, 32'hCAFE_BABE, 1, st);
    check("size11_is_word", ReadDataM, 32'hCAFE_BABE);

    run(0, 2'b10, 0, 32'h102, 32'h0, 32'h1234_5678, 1, st);
`ifdef MISALIGN_TRAP_EN
    check("lw_misaligned_trapped", ReadDataM, 32'hCAFE_BABE);
    check("lw_misaligned_stall", 32'(st), 1);
`else
    check("lw_forced_aligned", ReadDataM, 32'h1234_5678);
    check("lw_forced_addr", 32'(obs_addr), 32'h40);
`endif

    // Async reset in the middle of a request.
    exp_we = 1'b0; exp_addr = 30'h0C0; exp_be = 4'hF; exp_wdata = 32'h0;
    @(posedge clk); #1;
    MemReadEnM = 1'b1; MemSizeM = 2'b10; LoadSizeM = 2'b00; ALUResultM = 32'h300; ReadData2M = 32'h0;
    repeat (3) @(posedge clk);
    #1 check("req_before_rst", 32'(mem_req), 1);
    #2 model_on = 0; rst = 1'b1;
    #1 check("rst_drops_req", 32'(mem_req), 0);
    check("rst_clears_ReadDataM", ReadDataM, 0);
    MemReadEnM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; exp_rdata = '0; model_on = 1;

    run(1, 2'b10, 0, 32'h0, 32'h1122_3344, 32'h0, 2, st);
    check("sw_after_rst_wdata", obs_wdata, 32'h1122_3344);
    check("sw_after_rst_be", 32'(obs_be), 32'hF);
    check("sw_after_rst_addr", 32'(obs_addr), 32'h0);
    check("sw_after_rst_stall", 32'(st), 3);

    model_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1);
  end

endmodule
